// File: rtl/mac_accum_stage.sv
// mac_accum_stage
// ---------------------------------------------------------------------------
// Accumulation ("AC") half of the reconfigurable MAC datapath. Sums a
// programmable-length frame of unsigned products coming from the multiplier
// into a wide accumulator and presents the frame result on a valid/ready
// output port, together with a sticky overflow flag.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset (discards any frame in flight)
//   start      begin a new frame (honoured in IDLE, or in DONE with out_ready)
//   len        number of products in the frame, sampled with start
//   in_valid   product on in_prod is valid
//   in_ready   stage accepts a product this cycle (state ACCUM)
//   in_prod    unsigned product from the multiplier
//   out_valid  frame result available (state DONE)
//   out_ready  downstream accepts the result
//   out_sum    frame sum, driven straight from the accumulator register
//   out_ovf    sticky flag: frame sum exceeded 2^ACC_W-1
//   busy       high in ACCUM or DONE
//
// Build option:
//   MAC_ACC_SAT_EN  when defined, the accumulator saturates at all-ones on
//                   overflow and stays there for the rest of the frame;
//                   when undefined, the accumulator wraps modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module mac_accum_stage #(
    parameter int PROD_W = 4,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    // One extra bit catches the carry out of the accumulator.
    logic [ACC_W:0]     sum_ext;

    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

    // Outputs are decoded from registered state only.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = len;
                    state_d = (len != '0) ? ACCUM : DONE;
                end
            end

            ACCUM: begin
                // start is deliberately ignored while a frame is running.
                if (in_valid) begin
`ifdef MAC_ACC_SAT_EN
                    // Once overflowed, the accumulator is pinned at all-ones.
                    if (sum_ext[ACC_W] || ovf_q) begin
                        acc_d = '1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
`else
                    acc_d = sum_ext[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // Result is held until accepted; a start alongside the
                // acceptance loads the next frame with no idle bubble.
                if (out_ready) begin
                    if (start) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        cnt_d = len;
                        state_d = (len != '0) ? ACCUM : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Testbench for mac_accum_stage, built with an 8-bit accumulator so that
// overflow is reachable within one frame. Expected frame results are computed
// from the list of products with plain integer arithmetic and queued when the
// frame is started; a monitor pops and compares on every output handshake.
module tb_mac_accum_stage;

    localparam int PROD_W = 4;
    localparam int ACC_W  = 8;
    localparam int CNT_W  = 8;
    localparam int MAXV   = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    always #5 clk = ~clk;

    mac_accum_stage #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   frame_q[$];
    int   exp_sum;
    bit   exp_ovf;
    exp_t mon_e;

    function automatic void chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endfunction

    // Reference: total of the frame's products, then wrap or clamp.
    function automatic void push_expected();
        int   total;
        exp_t x;
        total = 0;
        foreach (frame_q[i]) total += frame_q[i];
        x.ovf = (total > MAXV);
`ifdef MAC_ACC_SAT_EN
        x.sum = x.ovf ? MAXV : total;
`else
        x.sum = total % (MAXV + 1);
`endif
        exp_sum = int'(x.sum);
        exp_ovf = x.ovf;
        exp_q.push_back(x);
    endfunction

    // Monitor: a result handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_sum", longint'(out_sum), longint'(mon_e.sum));
                chk("frame_ovf", longint'(out_ovf), longint'(mon_e.ovf));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input bit do_push);
        start = 1'b1;
        len   = CNT_W'(frame_q.size());
        if (do_push) push_expected();
        step();
        start = 1'b0;
        @(negedge clk);
        if (frame_q.size() == 0) begin
            chk("zero_len_valid", out_valid, 1);
            chk("zero_len_sum", longint'(out_sum), 0);
        end else begin
            chk("load_in_ready", in_ready, 1);
            chk("load_acc_zero", longint'(out_sum), 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Feed the first n products of frame_q with random gaps in [glo,ghi];
    // with noise, start/len wiggle while the frame runs and must be ignored.
    task automatic feed(input int n, input int glo, input int ghi, input bit noise);
        int t;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_prod  = PROD_W'(frame_q[i]);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                len   = CNT_W'($urandom_range(0, 255));
            end
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
            if (i != n - 1) begin
                repeat ($urandom_range(glo, ghi)) begin
                    if (noise) start = 1'($urandom_range(0, 1));
                    step();
                end
                start = 1'b0;
            end
        end
        if (n == frame_q.size() && n > 0) begin
            @(negedge clk);
            chk("done_valid_latency", out_valid, 1);
            chk("done_in_ready", in_ready, 0);
            chk("done_busy", busy, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_done(input int hold, input bit start_noise);
        out_ready = 1'b0;
        repeat (hold) begin
            if (start_noise) begin
                start = 1'b1;
                len   = CNT_W'($urandom_range(0, 255));
            end
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", longint'(out_sum), longint'(exp_sum));
            chk("hold_ovf", longint'(out_ovf), longint'(exp_ovf));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_keeps_sum", longint'(out_sum), longint'(exp_sum));
        @(posedge clk);
        #1;
    endtask

    // Accept the current result and load frame_q in the same cycle.
    task automatic back_to_back();
        out_ready = 1'b1;
        start     = 1'b1;
        len       = CNT_W'(frame_q.size());
        push_expected();
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        if (frame_q.size() != 0) begin
            chk("b2b_in_ready", in_ready, 1);
            chk("b2b_acc_zero", longint'(out_sum), 0);
        end else begin
            chk("b2b_zero_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int n;

        // Reset state while rst is held.
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", longint'(out_sum), 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        #10;
        rst = 1'b0;
        step();

        // Basic frame.
        frame_q = '{9, 4, 15};
        load_frame(1'b1);
        feed(3, 0, 0, 1'b0);
        hold_done(1, 1'b0);
        release_done();

        // Overflow: 20 x 15 = 300.
        frame_q = {};
        repeat (20) frame_q.push_back(15);
        load_frame(1'b1);
        feed(20, 0, 0, 1'b0);
        hold_done(2, 1'b0);
        release_done();

        // Flow control, ignored start while stalled, then back-to-back.
        frame_q = '{1, 2, 3, 4};
        load_frame(1'b1);
        feed(4, 2, 2, 1'b0);
        hold_done(5, 1'b1);
        frame_q = '{7, 8};
        back_to_back();
        feed(2, 0, 0, 1'b0);
        hold_done(1, 1'b0);
        release_done();

        // Zero-length frame.
        frame_q = {};
        load_frame(1'b1);
        hold_done(1, 1'b0);
        release_done();

        // Reset mid-frame discards the frame.
        frame_q = '{5, 6, 7, 8, 9};
        load_frame(1'b0);
        feed(2, 0, 0, 1'b0);
        @(negedge clk);
        chk("mid_sum", longint'(out_sum), 11);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", longint'(out_sum), 0);
        chk("arst_out_ovf", out_ovf, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        frame_q = '{6};
        load_frame(1'b1);
        feed(1, 0, 0, 1'b0);
        hold_done(0, 1'b0);
        release_done();

        // Randomized frames, occasionally chained back-to-back.
        frame_q = '{3};
        load_frame(1'b1);
        feed(1, 0, 0, 1'b0);
        for (int f = 0; f < 14; f++) begin
            hold_done($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            frame_q = {};
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
            for (int k = 0; k < n; k++) begin
                frame_q.push_back(($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) == 1) begin
                back_to_back();
            end else begin
                release_done();
                load_frame(1'b1);
            end
            feed(n, 0, 3, 1'b1);
        end
        hold_done(1, 1'b0);
        release_done();

        // Every queued result must have been delivered.
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            step();
            t++;
        end
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
